mul_rsv_station: RTL and testbench
==================================

// Module: mul_rsv_station
// PURPOSE
//   Reservation station and issue scheduler for the single-cycle MUL unit. Buffers up to
//   DEPTH dispatched M-extension multiply ops, captures source operands off the CDB, and
//   issues the oldest operand-ready op to MUL each cycle. Sits between dispatch/rename and
//   MUL; honours mispredict flushes by ROB index.
// PARAMETERS
//   DEPTH      4    number of station entries (2..8)
//   TAG_W      7    physical register tag width (matches MUL rd width)
//   ROB_IDX_W  $clog2(`ROB_LEN)  ROB index width
// PORTS
//   clk            in   1          clock; all state updates on rising edge
//   rst            in   1          synchronous, active-high reset
//   disp_valid     in   1          dispatch presents an op
//   disp_ready     out  1          station has a free entry
//   disp_funct3    in   3          MUL/MULH/MULHSU/MULHU selector
//   disp_rob_idx   in   ROB_IDX_W  ROB index of op
//   disp_rd        in   TAG_W      destination tag
//   disp_rsN_tag   in   TAG_W      source N tag (N=1,2)
//   disp_rsN_rdy   in   1          source N value valid at dispatch
//   disp_rsN_data  in   32         source N value (used only when disp_rsN_rdy)
//   cdb_valid      in   1          CDB broadcast valid
//   cdb_tag        in   TAG_W      CDB result tag
//   cdb_data       in   32         CDB result value
//   mispredict     in   1          flush request this cycle
//   flush_mask     in   `ROB_LEN   bit i set => ROB index i is squashed
//   iss_valid      out  1          op presented to MUL
//   iss_ready      in   1          MUL accepts (mul_o_ready)
//   iss_funct3     out  3          to MUL funct3
//   iss_rs1_data   out  32         to MUL rs1_data
//   iss_rs2_data   out  32         to MUL rs2_data
//   iss_rob_idx    out  ROB_IDX_W  to MUL mul_i_rob_idx
//   iss_rd         out  TAG_W      to MUL mul_i_rd
//   occupancy      out  $clog2(DEPTH+1)  valid entry count (registered)
// BEHAVIOUR
//   Reset: all entries invalid, age state cleared, occupancy=0; so disp_ready=1, iss_valid=0,
//     iss_* data outputs 0 when iss_valid=0. Reset mid-operation discards all entries.
//   Entry state: valid, funct3, rob_idx, rd, per source {rdy, tag, data}, age info.
//   Allocate: disp_valid && disp_ready && !(mispredict && flush_mask[disp_rob_idx]) writes the
//     lowest-index free entry; entry marked youngest. disp_ready = any entry invalid at start of
//     cycle (entry freed by same-cycle issue is not reusable until next cycle).
//   Dispatch bypass: if disp_rsN_rdy=0 and cdb_valid && cdb_tag==disp_rsN_tag, entry stores
//     cdb_data with rdy=1.
//   Wakeup: for each valid entry, source with rdy=0 and cdb_valid && cdb_tag==tag captures
//     cdb_data, rdy=1 next edge. cdb_tag==0 never wakes anything.
//   Select (combinational): eligible = valid && rs1.rdy && rs2.rdy && !(mispredict &&
//     flush_mask[rob_idx]). iss_valid = any eligible; issue oldest eligible (dispatch order,
//     age matrix or equivalent). Entry woken or allocated this cycle is not eligible until next
//     cycle => min dispatch-to-issue latency 1 cycle.
//   Issue handshake: iss_valid && iss_ready frees the selected entry at the edge. iss_valid &&
//     !iss_ready: entry retained, outputs may change next cycle only if an older op becomes
//     eligible.
//   Flush: mispredict=1 invalidates every valid entry whose flush_mask[rob_idx]=1 at the edge;
//     surviving entries keep relative age. Flush+wakeup on same entry: flush wins.
//   occupancy = previous + alloc - issue_free - flushed; never exceeds DEPTH.
//   No arithmetic on data; funct3/data passed through unmodified.
// TESTING
//   1 Reset, dispatch MUL rob=3 rd=10 rs1=6 rs2=7 both rdy, iss_ready=1 -> next cycle iss_valid=1,
//     rs1_data=6 rs2_data=7 rob_idx=3; cycle after occupancy=0.
//   2 Dispatch A(rs1 tag 20 not rdy) then B(both rdy); CDB tag 20 data 5 in cycle 2 -> B issues
//     first, A issues cycle 3 with rs1_data=5.
//   3 Fill DEPTH=4 entries none ready -> disp_ready=0; extra disp_valid ignored; CDB wakes
//     entry 0 -> it issues; disp_ready=1 the cycle after the free.
//   4 Entries rob=1,2,5 all ready, iss_ready=0 for 3 cycles -> iss_rob_idx stays 1 (oldest);
//     then iss_ready=1 -> issue order 1,2,5.
//   5 Entries rob=4,6 ready; mispredict with flush_mask bit 6 set and same-cycle dispatch
//     rob=6 -> rob=6 entry removed, dispatch dropped, rob=4 still issues, occupancy=0 after.
//   6 Dispatch with rs2 tag 9 not rdy while CDB tag 9 data 0xFFFF_FFFF -> entry issues next
//     cycle with rs2_data=0xFFFF_FFFF; CDB tag 0 broadcast wakes nothing.

Source files
------------

// File: rtl/mul_rsv_station_if.sv
// rtl/mul_rsv_station_if.sv - dispatch, CDB, flush and issue bus of the MUL reservation station
// Purpose: groups every non-clock signal of mul_rsv_station into one bundle.
// Ports (signals):
//   disp_*            dispatch request with operands; disp_ready back to dispatch
//   cdb_*             result broadcast used for operand wakeup
//   mispredict/flush_mask  squash request, bit i of the mask kills ROB index i
//   iss_*             operand-ready op presented to the MUL unit, iss_ready from MUL
//   occupancy         registered count of valid entries
// Modports: master = surrounding pipeline, slave = reservation station.
interface mul_rsv_station_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 7,
    parameter int ROB_LEN   = 16,
    parameter int ROB_IDX_W = $clog2(ROB_LEN),
    parameter int OCC_W     = $clog2(DEPTH + 1)
);
    logic                 disp_valid;
    logic                 disp_ready;
    logic [2:0]           disp_funct3;
    logic [ROB_IDX_W-1:0] disp_rob_idx;
    logic [TAG_W-1:0]     disp_rd;
    logic [TAG_W-1:0]     disp_rs1_tag;
    logic                 disp_rs1_rdy;
    logic [31:0]          disp_rs1_data;
    logic [TAG_W-1:0]     disp_rs2_tag;
    logic                 disp_rs2_rdy;
    logic [31:0]          disp_rs2_data;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [31:0]          cdb_data;
    logic                 mispredict;
    logic [ROB_LEN-1:0]   flush_mask;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [2:0]           iss_funct3;
    logic [31:0]          iss_rs1_data;
    logic [31:0]          iss_rs2_data;
    logic [ROB_IDX_W-1:0] iss_rob_idx;
    logic [TAG_W-1:0]     iss_rd;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output disp_valid, disp_funct3, disp_rob_idx, disp_rd,
               disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
               disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask, iss_ready,
        input  disp_ready, iss_valid, iss_funct3, iss_rs1_data, iss_rs2_data,
               iss_rob_idx, iss_rd, occupancy
    );

    modport slave (
        input  disp_valid, disp_funct3, disp_rob_idx, disp_rd,
               disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
               disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, mispredict, flush_mask, iss_ready,
        output disp_ready, iss_valid, iss_funct3, iss_rs1_data, iss_rs2_data,
               iss_rob_idx, iss_rd, occupancy
    );
endinterface

// File: rtl/mul_rsv_station.sv
// rtl/mul_rsv_station.sv - reservation station and oldest-ready issue scheduler for the MUL unit
// Purpose: buffers up to DEPTH multiply ops, captures missing operands off the CDB and
//   issues the oldest operand-ready op each cycle; squashes entries on mispredict.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears every entry
//   bus  mul_rsv_station_if.slave (dispatch, CDB, flush, issue, occupancy)
module mul_rsv_station #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 7,
    parameter int ROB_LEN   = 16,
    parameter int ROB_IDX_W = $clog2(ROB_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    mul_rsv_station_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     rs1_rdy;
    logic [DEPTH-1:0]     rs2_rdy;
    logic [2:0]           funct3   [DEPTH];
    logic [ROB_IDX_W-1:0] rob_idx  [DEPTH];
    logic [TAG_W-1:0]     rd       [DEPTH];
    logic [TAG_W-1:0]     rs1_tag  [DEPTH];
    logic [TAG_W-1:0]     rs2_tag  [DEPTH];
    logic [31:0]          rs1_data [DEPTH];
    logic [31:0]          rs2_data [DEPTH];
    // older[i][j] = 1 means entry i was dispatched before entry j
    logic [DEPTH-1:0]     older    [DEPTH];
    logic [OCC_W-1:0]     occ;

    logic             cdb_ok;
    logic             alloc;
    logic             issue;
    logic             byp1;
    logic             byp2;
    logic [DEPTH-1:0] flushed;
    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] valid_next;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] alloc_idx;

    // Tag 0 is the hard-wired zero register and never carries a result
    assign cdb_ok = bus.cdb_valid && (bus.cdb_tag != '0);
    assign byp1   = !bus.disp_rs1_rdy && cdb_ok && (bus.cdb_tag == bus.disp_rs1_tag);
    assign byp2   = !bus.disp_rs2_rdy && cdb_ok && (bus.cdb_tag == bus.disp_rs2_tag);

    // Only entries free at the start of the cycle are offered to dispatch
    assign bus.disp_ready = !(&valid);
    assign alloc = bus.disp_valid && bus.disp_ready &&
                   !(bus.mispredict && bus.flush_mask[bus.disp_rob_idx]);

    always_comb begin
        flushed  = '0;
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flushed[i]  = valid[i] && bus.mispredict && bus.flush_mask[rob_idx[i]];
            eligible[i] = valid[i] && rs1_rdy[i] && rs2_rdy[i] && !flushed[i];
        end
    end

    // An eligible entry wins unless some other eligible entry is older than it
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && older[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_idx   = '0;
        alloc_idx = '0;
        alloc_oh  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        if (alloc) begin
            alloc_oh[alloc_idx] = 1'b1;
        end
    end

    assign issue = (|eligible) && bus.iss_ready;

    always_comb begin
        valid_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_next[i] = (valid[i] && !flushed[i] && !(issue && sel_oh[i])) || alloc_oh[i];
        end
    end

    assign bus.iss_valid    = |eligible;
    assign bus.iss_funct3   = bus.iss_valid ? funct3[sel_idx]   : '0;
    assign bus.iss_rs1_data = bus.iss_valid ? rs1_data[sel_idx] : '0;
    assign bus.iss_rs2_data = bus.iss_valid ? rs2_data[sel_idx] : '0;
    assign bus.iss_rob_idx  = bus.iss_valid ? rob_idx[sel_idx]  : '0;
    assign bus.iss_rd       = bus.iss_valid ? rd[sel_idx]       : '0;
    assign bus.occupancy    = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
            occ     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                funct3[i]   <= '0;
                rob_idx[i]  <= '0;
                rd[i]       <= '0;
                rs1_tag[i]  <= '0;
                rs2_tag[i]  <= '0;
                rs1_data[i] <= '0;
                rs2_data[i] <= '0;
                older[i]    <= '0;
            end
        end else begin
            valid <= valid_next;
            occ   <= OCC_W'($countones(valid_next));
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    funct3[i]   <= bus.disp_funct3;
                    rob_idx[i]  <= bus.disp_rob_idx;
                    rd[i]       <= bus.disp_rd;
                    rs1_tag[i]  <= bus.disp_rs1_tag;
                    rs2_tag[i]  <= bus.disp_rs2_tag;
                    rs1_rdy[i]  <= bus.disp_rs1_rdy || byp1;
                    rs2_rdy[i]  <= bus.disp_rs2_rdy || byp2;
                    rs1_data[i] <= bus.disp_rs1_rdy ? bus.disp_rs1_data : bus.cdb_data;
                    rs2_data[i] <= bus.disp_rs2_rdy ? bus.disp_rs2_data : bus.cdb_data;
                    // New entry is younger than everything already present
                    older[i]    <= '0;
                end else begin
                    older[i] <= older[i] | alloc_oh;
                    if (valid[i] && !rs1_rdy[i] && cdb_ok && bus.cdb_tag == rs1_tag[i]) begin
                        rs1_rdy[i]  <= 1'b1;
                        rs1_data[i] <= bus.cdb_data;
                    end
                    if (valid[i] && !rs2_rdy[i] && cdb_ok && bus.cdb_tag == rs2_tag[i]) begin
                        rs2_rdy[i]  <= 1'b1;
                        rs2_data[i] <= bus.cdb_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_rsv_station.sv
// tb/tb_mul_rsv_station.sv - self-checking bench for mul_rsv_station
module tb_mul_rsv_station;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mul_rsv_station_if bus();

    mul_rsv_station dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        dv;
        logic [3:0]  rob;
        logic [2:0]  f3;
        logic        r1;
        logic [6:0]  t1;
        logic [31:0] d1;
        logic        r2;
        logic [6:0]  t2;
        logic [31:0] d2;
        logic        cv;
        logic [6:0]  ct;
        logic [31:0] cd;
        logic        mp;
        logic [15:0] fm;
        logic        ir;
        logic        e_dr;
        logic        e_iv;
        logic [3:0]  e_rob;
        logic [2:0]  e_f3;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int dv, int rob, int f3, int r1, int t1, int d1,
                                int r2, int t2, int d2, int cv, int ct, int cd,
                                int mp, int fm, int ir, int edr, int eiv, int erob,
                                int ef3, int ed1, int ed2, int eocc);
        vec_t v;
        v.dv = 1'(dv);    v.rob = 4'(rob);  v.f3 = 3'(f3);
        v.r1 = 1'(r1);    v.t1 = 7'(t1);    v.d1 = 32'(d1);
        v.r2 = 1'(r2);    v.t2 = 7'(t2);    v.d2 = 32'(d2);
        v.cv = 1'(cv);    v.ct = 7'(ct);    v.cd = 32'(cd);
        v.mp = 1'(mp);    v.fm = 16'(fm);   v.ir = 1'(ir);
        v.e_dr = 1'(edr); v.e_iv = 1'(eiv); v.e_rob = 4'(erob); v.e_f3 = 3'(ef3);
        v.e_d1 = 32'(ed1); v.e_d2 = 32'(ed2); v.e_occ = 3'(eocc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.disp_valid    = v.dv;
        bus.disp_rob_idx  = v.rob;
        bus.disp_funct3   = v.f3;
        bus.disp_rd       = 7'(v.rob) + 7'd10;
        bus.disp_rs1_rdy  = v.r1;
        bus.disp_rs1_tag  = v.t1;
        bus.disp_rs1_data = v.d1;
        bus.disp_rs2_rdy  = v.r2;
        bus.disp_rs2_tag  = v.t2;
        bus.disp_rs2_data = v.d2;
        bus.cdb_valid     = v.cv;
        bus.cdb_tag       = v.ct;
        bus.cdb_data      = v.cd;
        bus.mispredict    = v.mp;
        bus.flush_mask    = v.fm;
        bus.iss_ready     = v.ir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic edr, input logic eiv,
                              input logic [3:0] erob, input logic [2:0] ef3,
                              input logic [31:0] ed1, input logic [31:0] ed2,
                              input logic [2:0] eocc);
        chk({tag, ".disp_ready"}, 32'(bus.disp_ready), 32'(edr));
        chk({tag, ".iss_valid"},  32'(bus.iss_valid),  32'(eiv));
        chk({tag, ".rob_idx"},    32'(bus.iss_rob_idx), eiv ? 32'(erob) : 32'd0);
        chk({tag, ".rd"},         32'(bus.iss_rd), eiv ? 32'(erob) + 32'd10 : 32'd0);
        chk({tag, ".funct3"},     32'(bus.iss_funct3), eiv ? 32'(ef3) : 32'd0);
        chk({tag, ".rs1_data"},   bus.iss_rs1_data, eiv ? ed1 : 32'd0);
        chk({tag, ".rs2_data"},   bus.iss_rs2_data, eiv ? ed2 : 32'd0);
        chk({tag, ".occupancy"},  32'(bus.occupancy), 32'(eocc));
    endtask

    task automatic idle();
        drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1, 0,0,0,0,0,0,0));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // dv rob f3 | r1 t1 d1 | r2 t2 d2 | cv ct cd | mp fm | ir || edr eiv erob ef3 ed1 ed2 eocc
        // single op, both sources ready, issues one cycle after dispatch
        vq.push_back(mk(1,3,0, 1,0,6,  1,0,7,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,3,0,6,7,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // older op waiting on tag 20, younger ready op overtakes it
        vq.push_back(mk(1,1,1, 0,20,0, 1,0,3,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        vq.push_back(mk(1,2,2, 1,0,8,  1,0,9,  0,0,0, 0,0, 1, 1,0,0,0,0,0,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  1,20,5, 0,0, 1, 1,1,2,2,8,9,2));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,1,1,5,3,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // three ready ops held by iss_ready=0, then drained oldest first
        vq.push_back(mk(1,1,0, 1,0,11, 1,0,12, 0,0,0, 0,0, 0, 1,0,0,0,0,0,0));
        vq.push_back(mk(1,2,1, 1,0,21, 1,0,22, 0,0,0, 0,0, 0, 1,1,1,0,11,12,1));
        vq.push_back(mk(1,5,3, 1,0,51, 1,0,52, 0,0,0, 0,0, 0, 1,1,1,0,11,12,2));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 0, 1,1,1,0,11,12,3));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,1,0,11,12,3));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,2,1,21,22,2));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,5,3,51,52,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // flush rob 6 with same-cycle dispatch of rob 6
        vq.push_back(mk(1,4,2, 1,0,41, 1,0,42, 0,0,0, 0,0, 0, 1,0,0,0,0,0,0));
        vq.push_back(mk(1,6,0, 1,0,61, 1,0,62, 0,0,0, 0,0, 0, 1,1,4,2,41,42,1));
        vq.push_back(mk(1,6,1, 1,0,63, 1,0,64, 0,0,0, 1,16'h0040, 0, 1,1,4,2,41,42,2));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 0, 1,1,4,2,41,42,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,4,2,41,42,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // flushing the only ready entry suppresses its issue that same cycle
        vq.push_back(mk(1,2,0, 1,0,1,  1,0,2,  0,0,0, 0,0, 0, 1,0,0,0,0,0,0));
        vq.push_back(mk(1,3,0, 1,0,3,  1,0,4,  0,0,0, 1,16'h0004, 1, 1,0,0,0,0,0,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,3,0,3,4,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // dispatch bypass of rs2 from CDB tag 9
        vq.push_back(mk(1,7,3, 1,0,2,  0,9,0,  1,9,32'hFFFF_FFFF, 0,0, 1, 1,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,1,7,3,2,32'hFFFF_FFFF,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));
        // tag 0 never wakes, neither at dispatch nor while waiting; flushed to clean up
        vq.push_back(mk(1,8,0, 1,0,1,  0,0,0,  1,0,32'h55, 0,0, 1, 1,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  1,0,32'h66, 0,0, 1, 1,0,0,0,0,0,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 1,16'h0100, 1, 1,0,0,0,0,0,1));
        vq.push_back(mk(0,0,0, 0,0,0,  0,0,0,  0,0,0, 0,0, 1, 1,0,0,0,0,0,0));

        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd0);
        step();

        foreach (vq[n]) begin
            drive(vq[n]);
            @(negedge clk);
            check_outs($sformatf("row%0d", n), vq[n].e_dr, vq[n].e_iv, vq[n].e_rob,
                       vq[n].e_f3, vq[n].e_d1, vq[n].e_d2, vq[n].e_occ);
            step();
        end

        // fill all four entries with rs1 pending on tags 30..33
        for (int k = 0; k < 4; k++) begin
            drive(mk(1,k,0, 0,30+k,0, 1,0,32'h100+k, 0,0,0, 0,0, 1, 0,0,0,0,0,0,0));
            step();
        end
        idle();
        @(negedge clk);
        check_outs("full", 1'b0, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd4);
        step();
        // dispatch while full is ignored
        drive(mk(1,9,0, 1,0,1, 1,0,2, 0,0,0, 0,0, 1, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("full_extra.disp_ready", 32'(bus.disp_ready), 32'd0);
        step();
        idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 7'd30;
        bus.cdb_data  = 32'h77;
        @(negedge clk);
        check_outs("full_wake", 1'b0, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd4);
        step();
        // entry 0 issues; slot freed by this issue is not offered in the same cycle
        drive(mk(1,10,0, 1,0,1, 1,0,2, 0,0,0, 0,0, 1, 0,0,0,0,0,0,0));
        @(negedge clk);
        check_outs("full_issue", 1'b0, 1'b1, 4'd0, 3'd0, 32'h77, 32'h100, 3'd4);
        step();
        idle();
        @(negedge clk);
        check_outs("after_free", 1'b1, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd3);

        // reset with three entries still pending discards them
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_outs("mid_reset", 1'b1, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
